// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator arithmetic stage.
//   - operator codes (low nibble of the keyboard decoder's operator entries)
//   - control state encoding for calc_alu_seq
//   - BCD digit width used by bin2bcd and the display interface
package calc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_NAND = 4'h7;
    localparam logic [3:0] OP_XNOR = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_OP,
        S_WAIT_B,
        S_EXEC,
        S_BCD,
        S_DONE
    } state_t;

    // Codes B..F carry no operation and are dropped by the entry logic.
    function automatic logic op_valid(input logic [3:0] code);
        return code <= OP_MUL;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: iterative double-dabble binary to packed-BCD converter.
//   clk, rst : clock, synchronous active-high reset (control only)
//   start    : one-cycle pulse, samples bin and restarts any conversion
//   bin      : WIDTH-bit unsigned value to convert
//   busy     : high while shift cycles remain
//   done     : one-cycle pulse on the edge of the last shift
//   bcd      : packed BCD result, digit 0 in bits [3:0]; stable until next start
module bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [WIDTH-1:0]                       bin,
    output logic                                   busy,
    output logic                                   done,
    output logic [calc_pkg::BCD_DIGIT_W*DIGITS-1:0] bcd
);
    import calc_pkg::*;

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh;
    logic [BCD_W-1:0] bcd_r;
    logic [CNT_W-1:0] cnt;

    // Any digit of 5 or more gets +3 so that the following left shift
    // carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[BCD_DIGIT_W*i +: BCD_DIGIT_W] >= 4'd5)
                r[BCD_DIGIT_W*i +: BCD_DIGIT_W] = r[BCD_DIGIT_W*i +: BCD_DIGIT_W] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sh    <= bin;
                bcd_r <= '0;
                cnt   <= CNT_W'(WIDTH);
            end else if (cnt != '0) begin
                {bcd_r, sh} <= {dabble_adjust(bcd_r), sh} << 1;
                cnt         <= cnt - 1'b1;
                if (cnt == CNT_W'(1))
                    done <= 1'b1;
            end
        end
    end

    assign busy = (cnt != '0);
    assign bcd  = bcd_r;

endmodule

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: sequential calculator stage behind the PS/2 decoder.
// Collects operand A, an operator and operand B, executes the operation
// (single-cycle logic/add/sub, iterative shift-add multiply and restoring
// divide), converts the result to BCD and emits a one-cycle result strobe.
// The result becomes the next operand A so calculations chain.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear, back to WAIT_A, keeps res_* outputs
//   in_valid   : entry strobe; in_is_oper selects operator vs operand
//   in_data    : operand value, or operator code in [3:0]
//   in_ready   : high while waiting for entries
//   busy       : high while executing / converting / presenting result
//   res_valid  : one-cycle result strobe
//   res_data   : binary result, res_bcd its packed BCD, res_err error flag
module calc_alu_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic                  in_is_oper,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic [4*DIGITS-1:0]   res_bcd,
    output logic                  res_err
);
    import calc_pkg::*;

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a, b;
    logic [3:0]         op;
    logic [CNT_W-1:0]   cnt;
    // Shared iteration registers: product {hi,lo} for MUL,
    // remainder hi / dividend-quotient lo for DIV.
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   res_hold;
    logic               err_hold;

    logic [WIDTH:0]     add_w, sub_w, mul_sum, div_r;
    logic [WIDTH-1:0]   div_r_n;
    logic               div_q;
    logic [WIDTH-1:0]   hi_n, lo_n, exec_res;
    logic               exec_err, exec_done;

    logic               bcd_start, bcd_busy, bcd_done;
    logic [4*DIGITS-1:0] bcd;

    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
        div_r   = {hi, lo[WIDTH-1]};
        div_q   = (div_r >= {1'b0, b});
        div_r_n = div_q ? WIDTH'(div_r - {1'b0, b}) : div_r[WIDTH-1:0];

        hi_n      = hi;
        lo_n      = lo;
        exec_res  = '0;
        exec_err  = 1'b0;
        exec_done = 1'b1;
        case (op)
            OP_ADD:  begin exec_res = add_w[WIDTH-1:0]; exec_err = add_w[WIDTH]; end
            OP_SUB:  begin exec_res = sub_w[WIDTH-1:0]; exec_err = sub_w[WIDTH]; end
            OP_AND:  exec_res = a & b;
            OP_XOR:  exec_res = a ^ b;
            OP_NOT:  exec_res = ~a;
            OP_OR:   exec_res = a | b;
            OP_NOR:  exec_res = ~(a | b);
            OP_NAND: exec_res = ~(a & b);
            OP_XNOR: exec_res = ~(a ^ b);
            OP_MUL: begin
                hi_n      = mul_sum[WIDTH:1];
                lo_n      = {mul_sum[0], lo[WIDTH-1:1]};
                exec_done = (cnt == CNT_W'(WIDTH - 1));
                exec_res  = lo_n;
                exec_err  = |hi_n;
            end
            OP_DIV: begin
                if (b == '0) begin
                    exec_res = '1;
                    exec_err = 1'b1;
                end else begin
                    hi_n      = div_r_n;
                    lo_n      = {lo[WIDTH-2:0], div_q};
                    exec_done = (cnt == CNT_W'(WIDTH - 1));
                    exec_res  = lo_n;
                end
            end
            default: exec_res = '0;
        endcase
    end

    // The converter samples the final EXEC value on the same edge that
    // leaves EXEC, so its WIDTH shifts follow immediately.
    assign bcd_start = (state == S_EXEC) && exec_done && !clr;

    bin2bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (bcd_start),
        .bin   (exec_res),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT_A;
            a         <= '0;
            b         <= '0;
            op        <= OP_ADD;
            cnt       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_bcd   <= '0;
            res_err   <= 1'b0;
        end else if (clr) begin
            state     <= S_WAIT_A;
            a         <= '0;
            b         <= '0;
            op        <= OP_ADD;
            cnt       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                S_WAIT_A: begin
                    if (in_valid && !in_is_oper) begin
                        a     <= in_data;
                        state <= S_WAIT_OP;
                    end
                end
                S_WAIT_OP, S_WAIT_B: begin
                    if (in_valid && !in_is_oper) begin
                        if (state == S_WAIT_OP) begin
                            a <= in_data;
                        end else begin
                            b        <= in_data;
                            hi       <= '0;
                            lo       <= (op == OP_MUL) ? in_data : a;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_EXEC;
                        end
                    end else if (in_valid && op_valid(in_data[3:0])) begin
                        op <= in_data[3:0];
                        if (in_data[3:0] == OP_NOT) begin
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_EXEC;
                        end else begin
                            state <= S_WAIT_B;
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= cnt + 1'b1;
                    hi  <= hi_n;
                    lo  <= lo_n;
                    if (exec_done) begin
                        res_hold <= exec_res;
                        err_hold <= exec_err;
                        state    <= S_BCD;
                    end
                end
                S_BCD: begin
                    // done pulses on the last shift, when the converter goes idle
                    if (bcd_done && !bcd_busy) begin
                        res_valid <= 1'b1;
                        res_data  <= res_hold;
                        res_bcd   <= bcd;
                        res_err   <= err_hold;
                        a         <= res_hold;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_WAIT_OP;
                end
                default: state <= S_WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_seq.sv
// Scoreboard bench for calc_alu_seq: expected results are queued when the
// B operand (or NOT) is accepted and compared when res_valid fires.
module tb_calc_alu_seq;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                clk = 1'b0;
    logic                rst, clr, in_valid, in_is_oper;
    logic [WIDTH-1:0]    in_data;
    logic                in_ready, busy, res_valid, res_err;
    logic [WIDTH-1:0]    res_data;
    logic [4*DIGITS-1:0] res_bcd;

    calc_alu_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_is_oper (in_is_oper),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_bcd    (res_bcd),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0]    data;
        logic                err;
        logic [4*DIGITS-1:0] bcd;
        int                  t;
        int                  lat;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] model_a = '0;
    logic [WIDTH-1:0] last_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = int'(v);
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] av, input logic [3:0] opc,
                            input logic [WIDTH-1:0] bv, input int t);
        exp_t e;
        logic [31:0] p;
        logic [WIDTH:0] s;
        e.err = 1'b0;
        e.lat = 18;
        case (opc)
            4'h0: begin s = {1'b0, av} + {1'b0, bv}; e.data = s[WIDTH-1:0]; e.err = s[WIDTH]; end
            4'h1: begin e.data = av - bv; e.err = (av < bv); end
            4'h2: e.data = av & bv;
            4'h3: e.data = av ^ bv;
            4'h4: e.data = ~av;
            4'h5: e.data = av | bv;
            4'h6: e.data = ~(av | bv);
            4'h7: e.data = ~(av & bv);
            4'h8: e.data = ~(av ^ bv);
            4'h9: begin
                if (bv == 0) begin e.data = '1; e.err = 1'b1; end
                else begin e.data = av / bv; e.lat = 33; end
            end
            default: begin
                p = 32'(av) * 32'(bv);
                e.data = p[15:0];
                e.err = (p[31:16] != 0);
                e.lat = 33;
            end
        endcase
        e.bcd = to_bcd(e.data);
        e.t = t;
        sbq.push_back(e);
    endtask

    task automatic send(input bit is_op, input logic [WIDTH-1:0] d, output int t);
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_oper = is_op;
        in_data    = d;
        @(posedge clk);
        #1;
        t = cyc;
        in_valid   = 1'b0;
        in_is_oper = 1'b0;
        in_data    = '0;
    endtask

    task automatic wait_res(input string tag);
        bit seen;
        exp_t e;
        seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sbq.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check({tag, "_data"}, 32'(res_data), 32'(e.data));
            check({tag, "_err"}, 32'(res_err), 32'(e.err));
            check({tag, "_bcd"}, 32'(res_bcd), 32'(e.bcd));
            check({tag, "_lat"}, 32'(cyc - e.t), 32'(e.lat));
            model_a  = e.data;
            last_res = e.data;
            @(negedge clk);
            check({tag, "_pulse"}, 32'(res_valid), 32'd0);
        end
    endtask

    task automatic load_a(input logic [WIDTH-1:0] v);
        int t;
        send(1'b0, v, t);
        model_a = v;
    endtask

    task automatic run_op(input string tag, input logic [3:0] opc, input logic [WIDTH-1:0] bv);
        int t;
        send(1'b1, 16'(opc), t);
        if (opc != 4'h4) send(1'b0, bv, t);
        push_exp(model_a, opc, bv, t);
        wait_res(tag);
    endtask

    task automatic no_result(input int n, input string tag);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (res_valid) hits++;
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    task automatic pulse_clr(input bit with_entry, input logic [WIDTH-1:0] d);
        @(negedge clk);
        clr        = 1'b1;
        in_valid   = with_entry;
        in_is_oper = 1'b0;
        in_data    = d;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        int t;
        logic [WIDTH-1:0] ra, rb;
        logic [3:0] rop;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_is_oper = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_bcd", 32'(res_bcd), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);

        // Basic add, then multiply with overflow
        load_a(16'd25);
        run_op("add", 4'h0, 16'd17);
        pulse_clr(1'b0, '0);
        load_a(16'd300);
        run_op("mul", 4'hA, 16'd300);

        // Divide, then chained divide by zero
        pulse_clr(1'b0, '0);
        load_a(16'd1000);
        run_op("div", 4'h9, 16'd7);
        run_op("div0", 4'h9, 16'd0);

        // Borrowing subtract, chained add
        pulse_clr(1'b0, '0);
        load_a(16'd5);
        run_op("sub", 4'h1, 16'd9);
        run_op("chain_add", 4'h0, 16'd10);

        // Entry-order rules
        pulse_clr(1'b0, '0);
        send(1'b1, 16'h0000, t);            // operator in WAIT_A ignored
        check("waita_op_ready", 32'(in_ready), 32'd1);
        load_a(16'd3);
        load_a(16'd8);                      // replaces A
        send(1'b1, 16'h0002, t);            // AND
        send(1'b1, 16'h0005, t);            // OR replaces AND
        send(1'b1, 16'h000C, t);            // invalid code ignored
        send(1'b0, 16'd5, t);
        push_exp(model_a, 4'h5, 16'd5, t);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_not_ready", 32'(in_ready), 32'd0);
        send(1'b0, 16'd999, t);             // dropped while busy
        wait_res("order_or");
        run_op("chain_xor", 4'h3, 16'd1);
        run_op("not", 4'h4, 16'd0);
        check("done_ready", 32'(in_ready), 32'd1);

        // Assorted operations with random operands
        for (int i = 0; i < 8; i++) begin
            pulse_clr(1'b0, '0);
            ra  = 16'($urandom);
            rb  = (i == 3) ? 16'd0 : 16'($urandom_range(0, 300));
            rop = 4'($urandom_range(0, 10));
            if (i < 7) rop = 4'(i + 2);
            load_a(ra);
            run_op("rand", rop, rb);
        end

        // clr mid-multiply, with a simultaneous entry that must be dropped
        pulse_clr(1'b0, '0);
        load_a(16'd300);
        send(1'b1, 16'h000A, t);
        send(1'b0, 16'd300, t);
        repeat (9) @(negedge clk);
        pulse_clr(1'b1, 16'd77);
        no_result(40, "clr_no_result");
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_res_data", 32'(res_data), 32'(last_res));
        send(1'b1, 16'h0000, t);            // must be ignored in WAIT_A
        load_a(16'd4);
        run_op("after_clr", 4'h0, 16'd1);

        // rst during BCD conversion
        pulse_clr(1'b0, '0);
        send(1'b0, 16'd25, t);
        send(1'b1, 16'h0000, t);
        send(1'b0, 16'd17, t);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_res_data", 32'(res_data), 32'd0);
        check("rstmid_res_bcd", 32'(res_bcd), 32'd0);
        check("rstmid_res_err", 32'(res_err), 32'd0);
        no_result(30, "rstmid_no_result");
        load_a(16'd2);
        run_op("after_rst", 4'h0, 16'd2);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_alu_seq.md
# calc_alu_seq

Sequential arithmetic stage downstream of the PS/2 keyboard receiver/decoder. It collects operand A, an operator and operand B from the decoder's entry stream, then executes the operation: single-cycle logic/add/sub, or iterative multiply/divide. It converts the result to packed BCD for the 7-segment display driver and returns it as a one-cycle result pulse. The result is retained as operand A so that calculations can be chained.

## Interface
- `WIDTH`, 16: operand/result width in bits.
- `DIGITS`, 5: BCD digits in `res_bcd`; must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `clr`, in, 1: synchronous clear pulse; discards any entry or operation in progress.
- `in_valid`, in, 1: one-cycle entry strobe (the decoder's done pulse).
- `in_is_oper`, in, 1: 1 means `in_data[3:0]` is an operator code; 0 means `in_data` is an operand.
- `in_data`, in, WIDTH: operand value or operator code.
- `in_ready`, out, 1: high in WAIT_A, WAIT_OP and WAIT_B.
- `busy`, out, 1: high in EXEC, BCD and DONE.
- `res_valid`, out, 1: one-cycle result strobe.
- `res_data`, out, WIDTH: binary result; holds until the next result.
- `res_bcd`, out, 4*DIGITS: packed BCD of `res_data`, digit 0 in bits [3:0].
- `res_err`, out, 1: error flag accompanying `res_data`.

## Operation
- Operator codes match the decoder's low nibble: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 NOT, 5 OR, 6 NOR, 7 NAND, 8 XNOR, 9 DIV, A MUL. Codes B–F are ignored.
- States: WAIT_A → WAIT_OP → WAIT_B → EXEC → BCD → DONE → WAIT_OP.
- WAIT_A:
  - operand: load A, go to WAIT_OP.
  - operator: ignored.
- WAIT_OP:
  - operand: replaces A.
  - valid operator: latch it. NOT goes directly to EXEC; all others go to WAIT_B.
- WAIT_B:
  - operand: load B, go to EXEC.
  - valid operator: replaces the latched operator. NOT replaces it and goes to EXEC.
- Arithmetic, all mod 2^WIDTH:
  - ADD: `res_err` = carry out.
  - SUB: A−B; `res_err` = borrow (A<B).
  - Logic ops (AND, XOR, NOT, OR, NOR, NAND, XNOR): bitwise, `res_err`=0. NOT operates on A only.
  - MUL: shift-add, WIDTH iterations. Result is the low WIDTH bits; `res_err` = any nonzero upper bit.
  - DIV: unsigned restoring division, WIDTH iterations, quotient only.
  - DIV with B=0: result all ones, `res_err`=1, single EXEC cycle, no iterations.
- BCD conversion: double-dabble on the EXEC result, WIDTH shift cycles.
- DONE: `res_valid`=1 for exactly one cycle. `res_data`, `res_bcd` and `res_err` update on the same edge that `res_valid` rises. A ← result, go to WAIT_OP.
- `clr`:
  - returns to WAIT_A from any state on the next edge;
  - clears A, B and the operator;
  - does not change `res_*` (the display keeps the last result);
  - if simultaneous with `in_valid`, `clr` wins and the entry is dropped.
- `in_valid` while `in_ready`=0: the entry is dropped silently; no queuing.

## Timing
- Reset values:
  - state WAIT_A, A=B=0;
  - `in_ready`=1, `busy`=0;
  - `res_valid`=0, `res_data`=0, `res_bcd`=0, `res_err`=0.
- `rst` mid-operation aborts immediately. No `res_valid` follows.
- Let cycle 0 be the edge accepting B (or NOT).
- EXEC length E: 1 cycle for ADD/SUB/logic/DIV-by-0; WIDTH cycles for MUL/DIV.
- BCD occupies cycles E+1 … E+WIDTH. `res_valid` is high in cycle E+WIDTH+1.
  - WIDTH=16: ADD → cycle 18, MUL/DIV → cycle 33.
- `in_ready` falls the cycle after acceptance and rises the cycle after DONE.
- Back-to-back entries are permitted on consecutive cycles in the wait states.

## Structure
- Package `calc_pkg`:
  - operator code localparams;
  - state encoding;
  - `BCD_DIGIT_W`=4.
- Sub-module `bin2bcd`:
  - parameters WIDTH, DIGITS;
  - ports `start` pulse, `bin` in, `busy`, `done` pulse, `bcd` out;
  - iterative double-dabble, WIDTH cycles.
- Shift-add multiplier and restoring divider share one WIDTH-cycle counter inside `calc_alu_seq`.

## Test plan
- A=25, op ADD, B=17 → `res_valid` at cycle 18, `res_data`=42, `res_bcd`=0x00042, `res_err`=0.
- A=300, op MUL, B=300 → `res_valid` at cycle 33, `res_data`=0x5F90 (90000 mod 65536 = 24464), `res_bcd`=0x24464, `res_err`=1.
- A=1000, op DIV, B=7 → `res_data`=142. Then DIV with B=0 → `res_data`=0xFFFF, `res_err`=1, `res_valid` at cycle 18.
- Chaining: 5 SUB 9 → `res_data`=0xFFFC, `res_err`=1. Then op ADD, B=10 → `res_data`=6 with no new A entry.
- Entry-order rules:
  - operator in WAIT_A is ignored;
  - operand 3 then operand 8 in WAIT_OP → A=8;
  - op AND then op OR in WAIT_B → OR applied;
  - `in_valid` during BUSY is dropped;
  - op code 0xC is ignored.
- `clr` during MUL cycle 10 → no `res_valid`, state WAIT_A, `res_data` unchanged. `rst` mid-BCD → all outputs at reset values.
